// File: rtl/apb_multi_sampler.sv
// Periodic APB write master: each PERIOD cycles snapshots NCH channels and writes them into per-channel address rings.
// Tick to psel is 1 cycle, 2 cycles per zero-wait transfer; pready_i stalls the frame, ticks landing mid-frame are dropped and counted.
module apb_multi_sampler #(
  parameter int PERIOD = 500_000,
  parameter int NCH    = 4,
  parameter int DW     = 32,
  parameter int AW     = 8,
  parameter int DEPTH  = 16,
  parameter int BASE   = 0
) (
  input  logic              pclk_i,
  input  logic              preset_i,
  input  logic              en_i,
  input  logic [NCH*DW-1:0] pdata_i,
  input  logic [DW-1:0]     prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [AW-1:0]     paddr_o,
  output logic [DW-1:0]     pwdata_o,
  output logic              frame_done_o,
  output logic [7:0]        err_cnt_o,
  output logic [7:0]        ovr_cnt_o
);

  localparam int TW = $clog2(PERIOD);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]              state;
  logic [TW-1:0]           timer;
  logic [CW-1:0]           ch;
  logic [IW-1:0]           idx;
  logic [NCH-1:0][DW-1:0]  shadow;

  logic tick;
  logic start;
  logic xfer_done;
  logic last_ch;
  logic frame_end;
  logic active;
  logic unused_prdata;

  assign tick      = (timer == '0);
  assign start     = tick && en_i;
  assign xfer_done = (state == S_ACCESS) && pready_i;
  assign last_ch   = (ch == CW'(NCH - 1));
  assign frame_end = xfer_done && last_ch;
  assign active    = (state != S_IDLE);

  // Write-only master: read data is accepted on the port but never used.
  assign unused_prdata = ^prdata_i;

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state        <= S_IDLE;
      timer        <= TW'(PERIOD - 1);
      ch           <= '0;
      idx          <= '0;
      shadow       <= '0;
      frame_done_o <= 1'b0;
      err_cnt_o    <= '0;
      ovr_cnt_o    <= '0;
    end else begin
      timer        <= tick ? TW'(PERIOD - 1) : timer - 1'b1;
      frame_done_o <= frame_end;

      case (state)
        S_IDLE: begin
          if (start) begin
            shadow <= pdata_i;
            ch     <= '0;
            state  <= S_SETUP;
          end
        end
        S_SETUP: state <= S_ACCESS;
        S_ACCESS: begin
          if (pready_i) begin
            if (!last_ch) begin
              ch    <= ch + 1'b1;
              state <= S_SETUP;
            end else begin
              idx <= (idx == IW'(DEPTH - 1)) ? '0 : idx + 1'b1;
              // A tick on the completing cycle chains straight into the next frame.
              if (start) begin
                shadow <= pdata_i;
                ch     <= '0;
                state  <= S_SETUP;
              end else begin
                state <= S_IDLE;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      if (xfer_done && pslverr_i && (err_cnt_o != 8'hFF))
        err_cnt_o <= err_cnt_o + 1'b1;

      if (start && active && !frame_end && (ovr_cnt_o != 8'hFF))
        ovr_cnt_o <= ovr_cnt_o + 1'b1;
    end
  end

  always_comb begin
    psel_o    = active;
    pwrite_o  = active;
    penable_o = (state == S_ACCESS);
    paddr_o   = '0;
    pwdata_o  = '0;
    if (active) begin
      paddr_o  = AW'(BASE) + AW'(ch) * AW'(DEPTH) + AW'(idx);
      pwdata_o = shadow[ch];
    end
  end

endmodule

// File: tb/tb_apb_multi_sampler.sv
// Bench for apb_multi_sampler: scripted APB slave with per-channel wait/error control and a frame-level reference model.
module tb_apb_multi_sampler;

  localparam int PERIOD = 20;
  localparam int NCH    = 4;
  localparam int DW     = 32;
  localparam int AW     = 8;
  localparam int DEPTH  = 4;
  localparam int BASE   = 'h10;
  localparam int EW     = AW + DW;

  logic              pclk_i;
  logic              preset_i;
  logic              en_i;
  logic [NCH*DW-1:0] pdata_i;
  logic [DW-1:0]     prdata_i;
  logic              pready_i;
  logic              pslverr_i;
  logic              psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [AW-1:0]     paddr_o;
  logic [DW-1:0]     pwdata_o;
  logic              frame_done_o;
  logic [7:0]        err_cnt_o;
  logic [7:0]        ovr_cnt_o;

  apb_multi_sampler #(
    .PERIOD(PERIOD), .NCH(NCH), .DW(DW), .AW(AW), .DEPTH(DEPTH), .BASE(BASE)
  ) dut (
    .pclk_i(pclk_i), .preset_i(preset_i), .en_i(en_i), .pdata_i(pdata_i),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .frame_done_o(frame_done_o),
    .err_cnt_o(err_cnt_o), .ovr_cnt_o(ovr_cnt_o)
  );

  int total = 0;
  int bad   = 0;

  int ncyc = 0;          // non-reset clock edges since the last reset
  int psel_cnt = 0;
  int fd_cnt = 0;
  int stab_bad = 0;
  int wait_cfg [NCH];
  logic [NCH-1:0] err_mask = '0;
  logic err_all = 1'b0;

  logic [EW-1:0] xq[$];     // transfers observed on the bus
  logic [EW-1:0] exp_q[$];  // transfers predicted by the model

  int wleft = 0;
  int sch = 0;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_data;

  initial pclk_i = 1'b0;
  always #5 pclk_i = ~pclk_i;

  always @(posedge pclk_i) begin
    if (preset_i) ncyc <= 0;
    else          ncyc <= ncyc + 1;
  end

  // Slave and bus monitor; a transfer is logged when pready_i is raised for the coming edge.
  always @(negedge pclk_i) begin
    if (psel_o) psel_cnt++;
    if (frame_done_o) fd_cnt++;
    if (psel_o && !penable_o) begin
      sch = (int'(paddr_o) - BASE) / DEPTH;
      if (sch < 0 || sch >= NCH) sch = 0;
      wleft = wait_cfg[sch];
      hold_addr = paddr_o;
      hold_data = pwdata_o;
      pready_i = 1'b0;
      pslverr_i = 1'b0;
    end else if (psel_o && penable_o) begin
      if (paddr_o !== hold_addr || pwdata_o !== hold_data) stab_bad++;
      if (wleft == 0) begin
        pready_i = 1'b1;
        pslverr_i = err_all || err_mask[sch];
        xq.push_back({paddr_o, pwdata_o});
      end else begin
        wleft--;
        pready_i = 1'b0;
        pslverr_i = 1'b0;
      end
    end else begin
      pready_i = 1'b0;
      pslverr_i = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  function automatic logic [NCH*DW-1:0] rand_pdata();
    logic [NCH*DW-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*DW +: DW] = $urandom();
    return v;
  endfunction

  // Frame k writes channel c at BASE + c*DEPTH + (k mod DEPTH) with the snapshot taken at its tick.
  task automatic model_frame(input int k, input logic [NCH*DW-1:0] snap);
    logic [AW-1:0] a;
    for (int c = 0; c < NCH; c++) begin
      a = AW'(BASE + c * DEPTH + (k % DEPTH));
      exp_q.push_back({a, snap[c*DW +: DW]});
    end
  endtask

  task automatic wait_ncyc(input int n);
    while (ncyc < n) @(negedge pclk_i);
  endtask

  task automatic do_reset();
    @(negedge pclk_i);
    preset_i = 1'b1;
    repeat (3) @(negedge pclk_i);
    preset_i = 1'b0;
    xq.delete();
    exp_q.delete();
    psel_cnt = 0;
    fd_cnt = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge pclk_i);
    total++; if (psel_o !== 1'b0)       begin bad++; $display("FAIL rst_psel: got %b want 0", psel_o); end
    total++; if (penable_o !== 1'b0)    begin bad++; $display("FAIL rst_penable: got %b want 0", penable_o); end
    total++; if (pwrite_o !== 1'b0)     begin bad++; $display("FAIL rst_pwrite: got %b want 0", pwrite_o); end
    total++; if (paddr_o !== '0)        begin bad++; $display("FAIL rst_paddr: got %h want 0", paddr_o); end
    total++; if (pwdata_o !== '0)       begin bad++; $display("FAIL rst_pwdata: got %h want 0", pwdata_o); end
    total++; if (frame_done_o !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got %b want 0", frame_done_o); end
    total++; if (err_cnt_o !== 8'd0)    begin bad++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt_o); end
    total++; if (ovr_cnt_o !== 8'd0)    begin bad++; $display("FAIL rst_ovr_cnt: got %0d want 0", ovr_cnt_o); end
  endtask

  task automatic test_first_frame();
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    for (int c = 0; c < NCH; c++) wait_cfg[c] = 0;
    pdata_i = {32'h44, 32'h33, 32'h22, 32'h11};
    do_reset();
    wait_ncyc(PERIOD - 1);
    total++; if (psel_o !== 1'b0) begin bad++; $display("FAIL ff_psel_pre_tick: got %b want 0", psel_o); end
    wait_ncyc(PERIOD);
    total++; if ({psel_o, penable_o, pwrite_o} !== 3'b101) begin bad++; $display("FAIL ff_setup: got %b want 101", {psel_o, penable_o, pwrite_o}); end
    wait_ncyc(PERIOD + 1);
    total++; if ({psel_o, penable_o} !== 2'b11) begin bad++; $display("FAIL ff_access: got %b want 11", {psel_o, penable_o}); end
    wait_ncyc(PERIOD + 7);
    total++; if (frame_done_o !== 1'b0) begin bad++; $display("FAIL ff_done_early: got %b want 0", frame_done_o); end
    wait_ncyc(PERIOD + 8);
    total++; if (frame_done_o !== 1'b1) begin bad++; $display("FAIL ff_done: got %b want 1", frame_done_o); end
    wait_ncyc(PERIOD + 9);
    total++; if (frame_done_o !== 1'b0) begin bad++; $display("FAIL ff_done_late: got %b want 0", frame_done_o); end
    wait_ncyc(PERIOD + 12);
    total++; if (psel_cnt !== 2 * NCH) begin bad++; $display("FAIL ff_psel_cycles: got %0d want %0d", psel_cnt, 2 * NCH); end
    total++; if (fd_cnt !== 1) begin bad++; $display("FAIL ff_done_pulses: got %0d want 1", fd_cnt); end
    total++; if (xq.size() != NCH) begin bad++; $display("FAIL ff_count: got %0d want %0d", xq.size(), NCH); end
    for (int i = 0; i < NCH; i++) begin
      if (i < xq.size()) begin
        ea = AW'(8'h10 + 4 * i);
        ed = DW'(32'h11 * (i + 1));
        total++;
        if (xq[i] !== {ea, ed}) begin bad++; $display("FAIL ff_xfer%0d: got %h want %h", i, xq[i], {ea, ed}); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [NCH*DW-1:0] snap;
    logic [AW-1:0] ea;
    xq.delete();
    exp_q.delete();
    for (int f = 1; f < 5; f++) begin
      wait_ncyc(PERIOD * (f + 1) - 3);
      for (int c = 0; c < NCH; c++) wait_cfg[c] = $urandom_range(0, 2);
      snap = rand_pdata();
      pdata_i = snap;
      model_frame(f, snap);
    end
    wait_ncyc(PERIOD * 6);
    total++; if (xq.size() != exp_q.size()) begin bad++; $display("FAIL wrap_count: got %0d want %0d", xq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < xq.size()) begin
        total++;
        if (xq[i] !== exp_q[i]) begin bad++; $display("FAIL wrap_xfer%0d: got %h want %h", i, xq[i], exp_q[i]); end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (12 + c < xq.size()) begin
        ea = AW'(8'h10 + 4 * c);
        total++;
        if (xq[12 + c][EW-1:DW] !== ea) begin bad++; $display("FAIL wrap_frame5_addr%0d: got %h want %h", c, xq[12 + c][EW-1:DW], ea); end
      end
    end
    total++; if (err_cnt_o !== 8'd0) begin bad++; $display("FAIL wrap_err_cnt: got %0d want 0", err_cnt_o); end
    total++; if (ovr_cnt_o !== 8'd0) begin bad++; $display("FAIL wrap_ovr_cnt: got %0d want 0", ovr_cnt_o); end
    total++; if (stab_bad !== 0) begin bad++; $display("FAIL wrap_stable: got %0d unstable cycles want 0", stab_bad); end
  endtask

  task automatic test_wait_overrun();
    logic [NCH*DW-1:0] snap;
    for (int c = 0; c < NCH; c++) wait_cfg[c] = 0;
    wait_cfg[1] = 30;
    snap = rand_pdata();
    pdata_i = snap;
    do_reset();
    model_frame(0, snap);
    wait_ncyc(58);
    wait_cfg[1] = 0;
    snap = rand_pdata();
    pdata_i = snap;
    model_frame(1, snap);
    wait_ncyc(59);
    total++; if (psel_o !== 1'b0) begin bad++; $display("FAIL wait_idle_gap: got %b want 0", psel_o); end
    wait_ncyc(60);
    total++; if (psel_o !== 1'b1) begin bad++; $display("FAIL wait_next_frame: got %b want 1", psel_o); end
    wait_ncyc(75);
    total++; if (ovr_cnt_o !== 8'd1) begin bad++; $display("FAIL wait_ovr_cnt: got %0d want 1", ovr_cnt_o); end
    total++; if (stab_bad !== 0) begin bad++; $display("FAIL wait_stable: got %0d unstable cycles want 0", stab_bad); end
    total++; if (xq.size() != exp_q.size()) begin bad++; $display("FAIL wait_count: got %0d want %0d", xq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < xq.size()) begin
        total++;
        if (xq[i] !== exp_q[i]) begin bad++; $display("FAIL wait_xfer%0d: got %h want %h", i, xq[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_slverr();
    logic [NCH*DW-1:0] snap;
    for (int c = 0; c < NCH; c++) wait_cfg[c] = 0;
    err_mask = 4'b1001;
    snap = rand_pdata();
    pdata_i = snap;
    do_reset();
    model_frame(0, snap);
    wait_ncyc(PERIOD + 10);
    total++; if (err_cnt_o !== 8'd2) begin bad++; $display("FAIL err_two: got %0d want 2", err_cnt_o); end
    total++; if (xq.size() != exp_q.size()) begin bad++; $display("FAIL err_count: got %0d want %0d", xq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < xq.size()) begin
        total++;
        if (xq[i] !== exp_q[i]) begin bad++; $display("FAIL err_xfer%0d: got %h want %h", i, xq[i], exp_q[i]); end
      end
    end
    err_mask = '0;
    err_all = 1'b1;
    wait_ncyc(PERIOD * 77 - 5);
    err_all = 1'b0;
    total++; if (xq.size() != 4 + 300) begin bad++; $display("FAIL err_xfer_total: got %0d want 304", xq.size()); end
    total++; if (err_cnt_o !== 8'd255) begin bad++; $display("FAIL err_saturate: got %0d want 255", err_cnt_o); end
  endtask

  task automatic test_enable_snapshot();
    logic [NCH*DW-1:0] snap;
    for (int c = 0; c < NCH; c++) wait_cfg[c] = 0;
    en_i = 1'b0;
    do_reset();
    wait_ncyc(70);
    total++; if (psel_cnt !== 0) begin bad++; $display("FAIL en_low_psel: got %0d cycles want 0", psel_cnt); end
    total++; if (ovr_cnt_o !== 8'd0) begin bad++; $display("FAIL en_low_ovr: got %0d want 0", ovr_cnt_o); end
    en_i = 1'b1;
    snap = rand_pdata();
    pdata_i = snap;
    model_frame(0, snap);
    wait_ncyc(81);
    pdata_i = rand_pdata();
    wait_ncyc(83);
    en_i = 1'b0;
    wait_ncyc(130);
    total++; if (fd_cnt !== 1) begin bad++; $display("FAIL en_done_pulses: got %0d want 1", fd_cnt); end
    total++; if (ovr_cnt_o !== 8'd0) begin bad++; $display("FAIL en_ovr: got %0d want 0", ovr_cnt_o); end
    total++; if (xq.size() != exp_q.size()) begin bad++; $display("FAIL en_count: got %0d want %0d", xq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < xq.size()) begin
        total++;
        if (xq[i] !== exp_q[i]) begin bad++; $display("FAIL en_snapshot%0d: got %h want %h", i, xq[i], exp_q[i]); end
      end
    end
    en_i = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [NCH*DW-1:0] snap;
    for (int c = 0; c < NCH; c++) wait_cfg[c] = 0;
    err_mask = 4'b0001;
    pdata_i = rand_pdata();
    do_reset();
    wait_ncyc(PERIOD + 5);
    total++; if (err_cnt_o !== 8'd1) begin bad++; $display("FAIL rmid_err_before: got %0d want 1", err_cnt_o); end
    total++; if ({psel_o, penable_o} !== 2'b11) begin bad++; $display("FAIL rmid_in_access: got %b want 11", {psel_o, penable_o}); end
    preset_i = 1'b1;
    @(negedge pclk_i);
    total++; if ({psel_o, penable_o, pwrite_o} !== 3'b000) begin bad++; $display("FAIL rmid_ctrl: got %b want 000", {psel_o, penable_o, pwrite_o}); end
    total++; if ({paddr_o, pwdata_o} !== '0) begin bad++; $display("FAIL rmid_addr_data: got %h want 0", {paddr_o, pwdata_o}); end
    total++; if ({err_cnt_o, ovr_cnt_o} !== 16'd0) begin bad++; $display("FAIL rmid_counters: got %h want 0", {err_cnt_o, ovr_cnt_o}); end
    total++; if (fd_cnt !== 0) begin bad++; $display("FAIL rmid_no_done: got %0d want 0", fd_cnt); end
    err_mask = '0;
    snap = rand_pdata();
    pdata_i = snap;
    preset_i = 1'b0;
    xq.delete();
    exp_q.delete();
    model_frame(0, snap);
    wait_ncyc(PERIOD + 12);
    total++; if (xq.size() != exp_q.size()) begin bad++; $display("FAIL rmid_count: got %0d want %0d", xq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < xq.size()) begin
        total++;
        if (xq[i] !== exp_q[i]) begin bad++; $display("FAIL rmid_xfer%0d: got %h want %h", i, xq[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    preset_i  = 1'b1;
    en_i      = 1'b1;
    pdata_i   = '0;
    prdata_i  = '0;
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    for (int c = 0; c < NCH; c++) wait_cfg[c] = 0;
    test_reset();
    test_first_frame();
    test_wrap();
    test_wait_overrun();
    test_slverr();
    test_enable_snapshot();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_multi_sampler.md
# apb_multi_sampler

Parametrised periodic APB write master: every PERIOD cycles it snapshots NCH parallel data channels and writes them as NCH back-to-back APB write transfers into per-channel circular address windows. It sits between the sample sources and the APB slave memory/peripheral, replacing the single-channel fixed-period sampler. Adds per-channel address rings, an enable, slave-error and overrun counting, and a frame-done strobe.

## Interface
- PERIOD, 500_000: tick interval in pclk cycles (≥ 2*NCH+1)
- NCH, 4: number of channels (≥ 1)
- DW, 32: data width per channel
- AW, 8: APB address width
- DEPTH, 16: ring entries per channel (power of two, ≥ 1)
- BASE, 0: base address of channel 0 ring; BASE+NCH*DEPTH ≤ 2^AW
- pclk_i  in  1  clock; single clock domain
- preset_i  in  1  reset, synchronous, active-high
- en_i  in  1  sampling enable
- pdata_i  in  NCH*DW  channel data, channel c at bits [c*DW +: DW]
- prdata_i  in  DW  unused (write-only master), kept for bus compatibility
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error, valid with pready_i
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB write
- paddr_o  out  AW  APB address
- pwdata_o  out  DW  APB write data
- frame_done_o  out  1  one-cycle pulse on completion of last channel transfer
- err_cnt_o  out  8  saturating count of transfers completed with pslverr_i
- ovr_cnt_o  out  8  saturating count of dropped ticks

## Operation
- Tick timer: loads PERIOD-1 in reset, decrements each cycle, reloads PERIOD-1 from 0; tick = (timer==0). Runs regardless of en_i.
- FSM states IDLE, SETUP, ACCESS.
  - IDLE: on tick && en_i → capture pdata_i into shadow register, ch←0, → SETUP. Tick with en_i low ignored (not an overrun).
  - SETUP: → ACCESS unconditionally.
  - ACCESS: wait while !pready_i. On pready_i: if ch<NCH-1 → ch←ch+1, SETUP. If ch==NCH-1 → frame_done_o pulse, idx←(idx+1) mod DEPTH; then if tick && en_i same cycle → new snapshot, ch←0, SETUP; else → IDLE.
- Outputs: psel_o=pwrite_o=(state≠IDLE); penable_o=(state==ACCESS); paddr_o=BASE+ch*DEPTH+idx, truncated to AW bits, 0 in IDLE; pwdata_o=shadow[ch], 0 in IDLE.
- Address/data stable across SETUP and all ACCESS wait cycles.
- pslverr_i sampled only when state==ACCESS && pready_i; increments err_cnt_o (saturate 255). No retry; sequence continues.
- Overrun: tick && en_i while state≠IDLE, excluding the ACCESS cycle completing ch==NCH-1, → ovr_cnt_o+1 (saturate 255); tick dropped, in-flight frame unaffected.
- Shadow register changes only at snapshot; pdata_i changes mid-frame do not alter pwdata_o.
- en_i deasserted mid-frame: frame completes; only new frames suppressed.

## Timing
- Reset values: state IDLE, all APB outputs 0, frame_done_o 0, err_cnt_o 0, ovr_cnt_o 0, idx 0, ch 0, timer PERIOD-1.
- Reset asserted mid-transfer: psel_o/penable_o low on the cycle after the reset edge; frame abandoned, no frame_done_o.
- First tick: cycle after PERIOD-1 non-reset edges.
- Tick in IDLE → psel_o high next cycle (SETUP), penable_o high the cycle after.
- Zero-wait slave: NCH transfers take 2*NCH cycles; frame_done_o asserted in the cycle after the last ACCESS cycle with pready_i... specifically registered: high exactly one cycle, the cycle following the completing ACCESS edge.
- idx wraps DEPTH-1 → 0 with no gap.

## Test plan
- PERIOD=20, NCH=4, DEPTH=4, BASE=0x10, zero-wait slave, pdata_i={4,3,2,1}×0x11: first frame writes 0x11@0x10, 0x22@0x14, 0x33@0x18, 0x44@0x1C; each psel phase 2 cycles; one frame_done_o pulse.
- Five frames same config: idx wraps; frame 5 addresses equal frame 1 (0x10,0x14,0x18,0x1C); err_cnt_o=ovr_cnt_o=0.
- Slave inserts 30 wait states on channel 1: addr/data held stable; one tick lands mid-frame → ovr_cnt_o=1, next frame starts at following tick.
- pslverr_i with pready_i on channels 0 and 3 of one frame → err_cnt_o=2, all four transfers still issued; 300 error transfers → err_cnt_o=255.
- en_i low for 3 ticks → no psel_o, ovr_cnt_o unchanged; pdata_i changed during a frame → written data equals snapshot values.
- preset_i asserted during ACCESS of channel 2 → next cycle all outputs 0, counters 0; first post-reset frame writes at idx 0.
